// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: sequential 32-bit unsigned multiply / restoring divide.
// Uses the shared combinational ALU as its only adder/subtractor.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, op, a, b     request (op 0 = mul, 1 = div), sampled in IDLE
//   busy, done          busy in RUN/DONE, done is a one-cycle pulse
//   hi, lo, div0        product hi/lo or remainder/quotient, div-by-zero flag
//   alu_src1, alu_src2  ALU operands
//   alu_ctrl, alu_bonus ALU control (ADD/SUB only), bonus tied to zero
//   alu_result, alu_cout combinational ALU response
module alu_muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [3:0]  alu_ctrl,
  output logic [2:0]  alu_bonus,
  input  logic [31:0] alu_result,
  input  logic        alu_cout
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state;
  logic        op_q;
  logic [4:0]  cnt;
  logic [31:0] acc;
  logic [31:0] q;
  logic [31:0] m;

  logic        run_mul;
  logic        run_div;
  logic [31:0] t;
  logic        take;
  logic [31:0] nxt_acc;
  logic [31:0] nxt_q;

  assign run_mul   = (state == S_RUN) && !op_q;
  assign run_div   = (state == S_RUN) &&  op_q;
  assign alu_bonus = 3'b000;

  // Divide: the bit shifted out of r (msb) makes the 33-bit partial
  // remainder exceed any divisor, so the subtract is taken regardless
  // of the ALU borrow.
  assign t    = {acc[30:0], q[31]};
  assign take = acc[31] | alu_cout;

  always_comb begin
    alu_src1 = '0;
    alu_src2 = '0;
    alu_ctrl = ALU_ADD;
    nxt_acc  = acc;
    nxt_q    = q;
    unique case (1'b1)
      run_mul: begin
        alu_src1 = acc;
        alu_src2 = q[0] ? m : 32'd0;
        alu_ctrl = ALU_ADD;
        nxt_acc  = {alu_cout, alu_result[31:1]};
        nxt_q    = {alu_result[0], q[31:1]};
      end
      run_div: begin
        alu_src1 = t;
        alu_src2 = m;
        alu_ctrl = ALU_SUB;
        if (take) begin
          nxt_acc = alu_result;
          nxt_q   = {q[30:0], 1'b1};
        end else begin
          nxt_acc = t;
          nxt_q   = {q[30:0], 1'b0};
        end
      end
      default: begin
        alu_src1 = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      q     <= '0;
      m     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      div0  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op;
            cnt  <= '0;
            acc  <= '0;
            q    <= op ? a : b;
            m    <= op ? b : a;
            busy <= 1'b1;
            if (op && (b == 32'd0)) begin
              hi    <= a;
              lo    <= '1;
              div0  <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc <= nxt_acc;
          q   <= nxt_q;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            hi    <= nxt_acc;
            lo    <= nxt_q;
            div0  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: self-checking bench for alu_muldiv_seq.
// Hosts a behavioural ALU and an arithmetic reference model.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div0;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_ctrl;
  logic [2:0]  alu_bonus;
  logic [31:0] alu_result;
  logic        alu_cout;

  int n_pass = 0;
  int n_tot  = 0;
  int bad_enc = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div0(div0),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
    .alu_bonus(alu_bonus), .alu_result(alu_result), .alu_cout(alu_cout)
  );

  // Behavioural ALU: ADD and SUB (a + ~b + 1), carry out on both.
  logic [32:0] sum;
  always_comb begin
    sum = '0;
    if (alu_ctrl == 4'b0110)
      sum = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
    else
      sum = {1'b0, alu_src1} + {1'b0, alu_src2};
    alu_result = sum[31:0];
    alu_cout   = sum[32];
  end

  always @(posedge clk)
    if (rst_n && ((alu_ctrl != 4'b0010 && alu_ctrl != 4'b0110) ||
                  alu_bonus != 3'b000))
      bad_enc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic void model(input bit o, input logic [31:0] x,
                                input logic [31:0] y,
                                output logic [31:0] eh,
                                output logic [31:0] el,
                                output logic ed);
    logic [63:0] p;
    ed = 1'b0;
    if (!o) begin
      p = 64'(x) * 64'(y);
      eh = p[63:32];
      el = p[31:0];
    end else if (y == 0) begin
      eh = x;
      el = 32'hFFFF_FFFF;
      ed = 1'b1;
    end else begin
      eh = x % y;
      el = x / y;
    end
  endfunction

  // Issue one op; optionally pulse start (with junk operands) at the
  // given cycle offsets. Latency counts clock edges after the start edge.
  task automatic do_op(input bit o, input logic [31:0] x,
                       input logic [31:0] y, input int p1, input int p2,
                       output logic [31:0] rh, output logic [31:0] rl,
                       output logic rd, output int lat,
                       output int nbusy, output int ndone);
    rh = '0; rl = '0; rd = 1'b0;
    lat = -1; nbusy = 0; ndone = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = ~o;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = c; rh = hi; rl = lo; rd = div0;
        end
      end
      if (c == p1 || c == p2) begin
        start = 1'b1; a = $urandom; b = $urandom; op = ~o;
      end else begin
        start = 1'b0;
      end
      if (!busy && c > 0) break;
    end
    start = 1'b0;
    if (lat < 0) $display("FAIL timeout: op %0d never signalled done", o);
  endtask

  typedef struct {
    bit          o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] eh;
    logic [31:0] el;
    logic        ed;
    int          elat;
  } vec_t;

  vec_t vt[7];

  logic [31:0] rh, rl, eh, el;
  logic        rd, ed;
  int          lat, nb, nd;

  initial begin
    vt[0] = '{0, 32'd7, 32'd6, 32'd0, 32'd42, 0, 32};
    vt[1] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 0, 32};
    vt[2] = '{1, 32'd100, 32'd7, 32'd2, 32'd14, 0, 32};
    vt[3] = '{1, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 0, 32};
    vt[4] = '{1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0, 32};
    vt[5] = '{1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1, 0};
    vt[6] = '{0, 32'd3, 32'd3, 32'd0, 32'd9, 0, 32};

    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div0", div0, 0);
    chk("rst_hilo", {hi, lo}, 0);
    chk("rst_alu", {alu_src1, alu_src2, alu_ctrl, alu_bonus},
        {64'd0, 4'b0010, 3'b000});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(vt[i].o, vt[i].x, vt[i].y, -1, -1, rh, rl, rd, lat, nb, nd);
      chk($sformatf("vec%0d_hi", i), rh, vt[i].eh);
      chk($sformatf("vec%0d_lo", i), rl, vt[i].el);
      chk($sformatf("vec%0d_div0", i), rd, vt[i].ed);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].elat);
      chk($sformatf("vec%0d_busy", i), nb, vt[i].elat + 1);
      chk($sformatf("vec%0d_ndone", i), nd, 1);
    end

    // Results hold in IDLE; ALU drive returns to idle values.
    chk("hold_lo", lo, 32'd9);
    chk("idle_alu", {alu_src1, alu_src2, alu_ctrl}, {64'd0, 4'b0010});

    // Starts during RUN are ignored.
    do_op(1'b1, 32'd1000, 32'd13, 5, 20, rh, rl, rd, lat, nb, nd);
    chk("ign_hi", rh, 32'd12);
    chk("ign_lo", rl, 32'd76);
    chk("ign_lat", lat, 32);
    chk("ign_ndone", nd, 1);
    chk("ign_idle", busy, 0);

    // Reset mid-multiply aborts.
    @(negedge clk);
    op = 1'b0; a = 32'd123; b = 32'd456; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hilo", {hi, lo}, 0);
    chk("abort_alu", {alu_src1, alu_src2, alu_ctrl}, {64'd0, 4'b0010});
    nd = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort_nodone", nd, 0);
    do_op(1'b0, 32'd123, 32'd456, -1, -1, rh, rl, rd, lat, nb, nd);
    chk("post_rst_lo", {rh, rl}, 64'd56088);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      bit          o;
      logic [31:0] x, y;
      o = 1'($urandom_range(0, 1));
      x = $urandom;
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      else if ($urandom_range(0, 3) == 0) y = $urandom_range(1, 15);
      else y = $urandom;
      model(o, x, y, eh, el, ed);
      do_op(o, x, y, -1, -1, rh, rl, rd, lat, nb, nd);
      chk($sformatf("rnd%0d_op%0d_%0h_%0h", i, o, x, y),
          {rh, rl}, {eh, el});
      chk($sformatf("rnd%0d_div0", i), rd, ed);
      chk($sformatf("rnd%0d_lat", i), lat, ed ? 0 : 32);
    end

    chk("alu_encodings", bad_enc, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Sequential 32-bit unsigned multiply/divide unit that drives the team's combinational 32-bit ALU as its only adder/subtractor. It is the initiator side of the ALU control interface: it sets src1/src2/ALU_control/bonus_control every cycle and consumes result/cout. It sits beside the ALU in the datapath and produces 64-bit products or quotient/remainder pairs over a start/busy/done handshake.

## Interface
- No parameters; the data width is fixed at 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = multiply, 1 = divide; sampled with start
- a  in  32  multiplicand / dividend; sampled with start
- b  in  32  multiplier / divisor; sampled with start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; hi/lo/div0 are valid from this cycle
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient
- div0  out  1  last divide had b == 0; updated with done
- alu_src1  out  32  to ALU src1
- alu_src2  out  32  to ALU src2
- alu_ctrl  out  4  to ALU ALU_control ({A_invert, B_invert/cin, operation[1:0]})
- alu_bonus  out  3  to ALU bonus_control; constant 3'b000
- alu_result  in  32  from ALU result (combinational, same cycle)
- alu_cout  in  1  from ALU cout (valid only for ADD/SUB encodings)

## Operation
- ALU encodings used: ADD = 4'b0010, SUB = 4'b0110. No other encodings are issued, and SLT/bonus logic is unused.
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches op, a, b, clears the iteration count, and goes to RUN. Exception: op=1 with b==0 goes directly to DONE with hi=a, lo=32'hFFFFFFFF, div0=1.
- RUN: 32 iterations, one per clock; RUN goes to DONE after iteration 32 (count 31).
- DONE: done=1 for one cycle, then IDLE unconditionally.
- Multiply: acc (32) = 0, q = b, m = a.
  - Drive src1=acc, src2 = q[0] ? m : 0, ctrl=ADD.
  - Update {acc, q} <= {alu_cout, alu_result, q[31:1]}.
  - At the end, hi=acc and lo=q.
- Divide (restoring): r (32) = 0, q = a, d = b.
  - Per iteration, t = {r[30:0], q[31]} and msb = r[31].
  - Drive src1=t, src2=d, ctrl=SUB.
  - If msb | alu_cout: r <= alu_result, q <= {q[30:0],1}.
  - Otherwise: r <= t, q <= {q[30:0],0}.
  - At the end, hi=r and lo=q.
- hi/lo/div0 are written only on the transition into DONE. They hold until the next completion. div0 is cleared on any non-div0 completion.
- In IDLE and DONE, the ALU drive is src1=0, src2=0, ctrl=ADD.

## Timing
- Reset (async assert, synchronous-to-clk release): state IDLE; busy=0, done=0, div0=0, hi=0, lo=0; internal regs 0; ALU drive at IDLE values.
- Latency: with start sampled at edge E0, done is high in the cycle after E32 for mul/div. For div-by-zero, done is high in the cycle after E0.
- busy rises in the cycle after the start edge. It falls when DONE exits, so a new start is accepted at the earliest in the cycle after done.
- start while busy=1 (RUN or DONE) is ignored and not queued. a/b/op changes during RUN have no effect.
- The ALU path is combinational within one cycle: alu_result/alu_cout are captured at the same edge that ends the cycle in which they were driven.
- Reset asserted mid-operation aborts: no done pulse, hi/lo go to 0.
- Mul results are full 64-bit and unsigned, with no overflow. Divide is unsigned. An all-ones dividend needs the msb path; it must not be dropped.

## Test plan
- Mul 7 × 6: start, op=0 -> done 32 cycles after the start edge; hi=0, lo=42, div0=0; busy high exactly 33 cycles.
- Mul 32'hFFFFFFFF × 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 (exercises cout capture).
- Div 100 / 7 -> lo=14, hi=2. Div 32'hFFFFFFFF / 1 -> lo=32'hFFFFFFFF, hi=0. Div 32'h80000000 / 32'hFFFFFFFF -> lo=0, hi=32'h80000000.
- Div 5 / 0 -> done in the cycle after the start edge; div0=1, hi=5, lo=32'hFFFFFFFF. A following mul 3 × 3 then clears div0, with lo=9.
- Start pulsed with different operands at cycles 5 and 20 of an op in progress -> ignored; only the original result appears, and exactly one done pulse.
- rst_n low at iteration 10 of a mul -> outputs 0 immediately, state IDLE, no done. A new start after release completes correctly.
